// File: rtl/vld_rdy_trace_recorder.sv
// Timestamping capture FIFO for a valid/ready trace tap, drained over its own valid/ready stream.
// Optional stall counter output enabled by defining TRACE_REC_STALL_CNT_EN.
module vld_rdy_trace_recorder #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned TSW   = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       tap_valid,
    input  logic                       tap_ready,
    input  logic [DATAW-1:0]           tap_data,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [TSW+DATAW-1:0]       rec_data,
    output logic [TSW-1:0]             clkcnt,
    output logic [15:0]                drop_cnt,
`ifdef TRACE_REC_STALL_CNT_EN
    output logic [31:0]                stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = TSW + DATAW;
    localparam logic [AW:0] PtrOne = (AW+1)'(1);
    localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

    logic [TSW-1:0] clkcnt_q;
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [15:0]    drop_cnt_q;
    logic [RW-1:0]  mem [DEPTH];

    logic [AW:0] level;
    logic        full, empty;
    logic        capture, pop, push, drop;

    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        full    = (level == LevelFull);
        empty   = (level == '0);
        capture = tap_valid && tap_ready && enable;
        pop     = !empty && rec_ready;
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clkcnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            clkcnt_q <= clkcnt_q + TSW'(1);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Storage is not reset; emptiness gates what is visible on rec_data.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= {clkcnt_q, tap_data};
        end
    end

`ifdef TRACE_REC_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (tap_valid && !tap_ready && enable && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign rec_valid  = !empty;
    assign rec_data   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign clkcnt     = clkcnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_vld_rdy_trace_recorder.sv
// Directed self-checking bench for vld_rdy_trace_recorder (DATAW=8, TSW=64, DEPTH=16).
// Covers the stall counter when TRACE_REC_STALL_CNT_EN is defined.
module tb_vld_rdy_trace_recorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tap_valid;
    logic        tap_ready;
    logic [7:0]  tap_data;
    logic        rec_valid;
    logic        rec_ready;
    logic [71:0] rec_data;
    logic [63:0] clkcnt;
    logic [15:0] drop_cnt;
    logic [4:0]  fifo_level;
`ifdef TRACE_REC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    vld_rdy_trace_recorder #(
        .DATAW (8),
        .TSW   (64),
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tap_valid  (tap_valid),
        .tap_ready  (tap_ready),
        .tap_data   (tap_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .clkcnt     (clkcnt),
        .drop_cnt   (drop_cnt),
`ifdef TRACE_REC_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tap;
        tap_valid = 1'b0;
        tap_ready = 1'b0;
        tap_data  = 8'h00;
        enable    = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_tap();
        rec_ready = 1'b0;
        do_reset();
        checks++;
        if (rec_valid !== 1'b0 || rec_data !== 72'd0 || clkcnt !== 64'd0 ||
            drop_cnt !== 16'd0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h clkcnt=%0d drop=%0d level=%0d, want all 0",
                     rec_valid, rec_data, clkcnt, drop_cnt, fifo_level);
        end
        repeat (10) tick();
        checks++;
        if (clkcnt !== 64'd10 || rec_valid !== 1'b0 || drop_cnt !== 16'd0 ||
            fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL idle10: clkcnt=%0d valid=%b drop=%0d level=%0d, want 10 0 0 0",
                     clkcnt, rec_valid, drop_cnt, fifo_level);
        end
    endtask

    task automatic test_capture;
        logic [71:0] exp_data;
        logic        exp_valid;
        idle_tap();
        do_reset();
        rec_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            exp_valid = 1'b1;
            case (cyc)
                6:       exp_data = {64'd5, 8'h11};
                7:       exp_data = {64'd6, 8'h22};
                10:      exp_data = {64'd9, 8'h33};
                default: begin exp_data = 72'd0; exp_valid = 1'b0; end
            endcase
            checks++;
            if (rec_valid !== exp_valid || rec_data !== exp_data) begin
                errors++;
                $display("FAIL capture_c%0d: valid=%b data=%h, want valid=%b data=%h",
                         cyc, rec_valid, rec_data, exp_valid, exp_data);
            end
            tap_valid = (cyc == 5 || cyc == 6 || cyc == 9);
            tap_ready = tap_valid;
            tap_data  = (cyc == 5) ? 8'h11 : (cyc == 6) ? 8'h22 : (cyc == 9) ? 8'h33 : 8'h00;
            tick();
        end
        idle_tap();
    endtask

    // Leaves the FIFO full at cycle 21 holding beats 0..15 (ts i, data i+1), drop_cnt 4.
    task automatic test_overflow;
        idle_tap();
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tap_valid = 1'b1;
            tap_ready = 1'b1;
            tap_data  = 8'(i + 1);
            tick();
        end
        // Cycle 20: handshake with enable low must not count as a drop.
        enable = 1'b0;
        tick();
        idle_tap();
        checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 16'd4 || clkcnt !== 64'd21) begin
            errors++;
            $display("FAIL overflow: level=%0d drop=%0d clkcnt=%0d, want 16 4 21",
                     fifo_level, drop_cnt, clkcnt);
        end
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== {64'd0, 8'h01}) begin
            errors++;
            $display("FAIL overflow_head: valid=%b data=%h, want 1 %h",
                     rec_valid, rec_data, {64'd0, 8'h01});
        end
    endtask

    task automatic test_full_push_pop;
        tap_valid = 1'b1;
        tap_ready = 1'b1;
        tap_data  = 8'hAA;
        rec_ready = 1'b1;
        tick();
        idle_tap();
        rec_ready = 1'b0;
        checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 16'd4 || rec_data !== {64'd1, 8'h02}) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d drop=%0d head=%h, want 16 4 %h",
                     fifo_level, drop_cnt, rec_data, {64'd1, 8'h02});
        end
    endtask

    task automatic test_drain_stall;
        logic [71:0] exp_q[$];
        int          idx;
        int          cyc;
        for (int i = 1; i < 16; i++) exp_q.push_back({64'(i), 8'(i + 1)});
        exp_q.push_back({64'd21, 8'hAA});
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 64) begin
            rec_ready = cyc[0];
            // Beats with enable low while the FIFO has room must still be ignored.
            enable    = 1'b0;
            tap_valid = 1'b1;
            tap_ready = 1'b1;
            tap_data  = 8'hEE;
            checks++;
            if (rec_valid !== 1'b1 || rec_data !== exp_q[idx]) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b data=%h, want 1 %h",
                         idx, rec_valid, rec_data, exp_q[idx]);
            end
            if (rec_ready) idx++;
            tick();
            cyc++;
        end
        idle_tap();
        rec_ready = 1'b0;
        checks++;
        if (idx != 16) begin
            errors++;
            $display("FAIL drain_timeout: drained=%0d, want 16", idx);
        end
        checks++;
        if (rec_valid !== 1'b0 || fifo_level !== 5'd0 || drop_cnt !== 16'd4) begin
            errors++;
            $display("FAIL drain_end: valid=%b level=%0d drop=%0d, want 0 0 4",
                     rec_valid, fifo_level, drop_cnt);
        end
    endtask

    task automatic test_reset_mid;
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tap_valid = 1'b1;
            tap_ready = 1'b1;
            tap_data  = 8'(8'h40 + i);
            tick();
        end
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++;
            $display("FAIL mid_queued: level=%0d, want 5", fifo_level);
        end
        tap_data = 8'h77;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        idle_tap();
        checks++;
        if (rec_valid !== 1'b0 || fifo_level !== 5'd0 || clkcnt !== 64'd0 ||
            drop_cnt !== 16'd0 || rec_data !== 72'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b level=%0d clkcnt=%0d drop=%0d data=%h, want all 0",
                     rec_valid, fifo_level, clkcnt, drop_cnt, rec_data);
        end
        tap_valid = 1'b1;
        tap_ready = 1'b1;
        tap_data  = 8'h5A;
        tick();
        idle_tap();
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== {64'd0, 8'h5A} || fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_capture: valid=%b data=%h level=%0d, want 1 %h 1",
                     rec_valid, rec_data, fifo_level, {64'd0, 8'h5A});
        end
    endtask

`ifdef TRACE_REC_STALL_CNT_EN
    task automatic test_stall_cnt;
        idle_tap();
        do_reset();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_reset: stall_cnt=%0d, want 0", stall_cnt);
        end
        tap_valid = 1'b1;
        tap_ready = 1'b0;
        repeat (7) tick();
        enable = 1'b0;
        repeat (2) tick();
        enable    = 1'b1;
        tap_ready = 1'b1;
        tick();
        idle_tap();
        checks++;
        if (stall_cnt !== 32'd7) begin
            errors++;
            $display("FAIL stall_cnt: stall_cnt=%0d, want 7", stall_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        rec_ready = 1'b0;
        idle_tap();
        test_reset();
        test_capture();
        test_overflow();
        test_full_push_pop();
        test_drain_stall();
        test_reset_mid();
`ifdef TRACE_REC_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vld_rdy_trace_recorder.md
# vld_rdy_trace_recorder

Synthesizable capture stage that sits directly downstream of a valid/ready/data trace tap. It timestamps every accepted handshake beat with a free-running cycle count and buffers the records in a FIFO. It then drains them over its own valid/ready stream to the trace agent's upload path. Overflow is never silent: lost beats are counted.

## Interface
- DATAW, 8, width of the tapped data bus
- TSW, 64, timestamp width (matches the longint cycle count used by the trace agent)
- DEPTH, 16, record FIFO depth; power of two, ≥2
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable; beats seen while low are ignored (not counted as drops)
- tap_valid  in  1  observed valid of the traced channel
- tap_ready  in  1  observed ready of the traced channel
- tap_data  in  DATAW  observed data of the traced channel
- rec_valid  out  1  record available
- rec_ready  in  1  downstream accepts record
- rec_data  out  TSW+DATAW  record, {timestamp[TSW-1:0], data[DATAW-1:0]}
- clkcnt  out  TSW  free-running cycle counter
- drop_cnt  out  16  beats lost to FIFO overflow, saturating
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- clkcnt: 0 out of reset, +1 every clk edge while rst low, wraps modulo 2^TSW; independent of enable.
- Capture event: tap_valid && tap_ready && enable sampled at a clk edge. Record = {clkcnt value in that cycle, tap_data}.
- Pop event: rec_valid && rec_ready at a clk edge.
- FIFO: circular buffer, rd/wr pointers with an extra wrap bit; full = level==DEPTH, empty = level==0.
- Push when not full: record written; level +1 (unless a simultaneous pop).
- Push when full, no pop in the same cycle: record discarded; drop_cnt +1, holding at 0xFFFF.
- Push and pop in the same cycle when full: pop frees the slot; push is accepted; no drop; level unchanged.
- Push and pop in the same cycle when empty: illegal state (rec_valid is 0), so only the push takes effect.
- Output: rec_data = head entry; rec_valid = !empty. While rec_valid && !rec_ready, rec_data holds stable.
- Records leave in capture order; timestamps are strictly increasing except across a clkcnt wrap.

## Timing
- Reset values: rec_valid 0, rec_data 0, clkcnt 0, drop_cnt 0, fifo_level 0. Pointers zero, FIFO contents discarded.
- Capture-to-output latency: 1 cycle. A beat captured at edge N makes rec_valid high after edge N. There is no combinational bypass from tap_* to rec_*.
- Pop takes effect at the edge; the next record, if any, is presented in the following cycle. Back-to-back drain sustains 1 record/cycle.
- rec_ready has no combinational path to any tap-side signal; tap-side inputs are never back-pressured.
- rst asserted mid-operation: at that edge all state returns to reset values, and any capture in that cycle is dropped without counting. The first capture after deassertion gets timestamp equal to clkcnt in that cycle (0 in the first cycle after reset).

## Configuration
- TRACE_REC_STALL_CNT_EN defined: adds output stall_cnt (32 bits, reset 0). It increments each cycle tap_valid && !tap_ready && enable, saturating at 0xFFFF_FFFF. It is cleared only by rst.
- Not defined: the stall_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle 10 cycles -> clkcnt=10, rec_valid=0, drop_cnt=0, fifo_level=0.
- Handshakes with data 0x11, 0x22, 0x33 at cycles 5,6,9, rec_ready=1 -> records {5,0x11},{6,0x22},{9,0x33}. Each appears 1 cycle after capture.
- rec_ready=0, DEPTH=16, 20 consecutive handshakes -> fifo_level=16, drop_cnt=4. Draining yields the first 16 beats in order.
- FIFO full, push and pop in the same cycle -> level stays 16, drop_cnt unchanged, new record appears last.
- rec_ready toggled 0/1 during drain -> rec_data stable while stalled; no duplicates or losses. enable=0 beats are never recorded.
- rst pulsed with 5 records queued -> next cycle rec_valid=0, level 0, clkcnt restarts at 0. With TRACE_REC_STALL_CNT_EN, 7 cycles of valid&&!ready give stall_cnt=7.
